// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised up/down counter.
// Direction encoding is driven straight from the up_down pin.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count selection for a modulo-(MAX_COUNT+1) up/down counter.
// The wrap output doubles as the terminal indication for the current direction.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (up_down == DIR_UP) begin
            if (count == MAX_VAL) begin
                wrap       = 1'b1;
                next_count = '0;
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                wrap       = 1'b1;
                next_count = MAX_VAL;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/param_sync_updown_counter.sv
// Cascadable synchronous up/down counter with saturating parallel load and
// a sticky wrap flag. Only count and wrap_flag are registered.
module param_sync_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             to_next_stage,
    output logic             wrap_flag
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_sat;

    counter_next_state #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next_state (
        .count      (count),
        .up_down    (up_down),
        .next_count (next_count),
        .wrap       (terminal)
    );

    // A wrap only happens when stepping, and a load always beats stepping.
    assign to_next_stage = terminal & count_enable & ~load;
    assign load_sat      = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wrap_flag <= 1'b0;
        end else begin
            if (load) begin
                count <= load_sat;
            end else if (count_enable) begin
                count <= next_count;
            end

            if (to_next_stage) begin
                wrap_flag <= 1'b1;
            end else if (clear_flag) begin
                wrap_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_sync_updown_counter.sv
// Self-checking bench: arithmetic reference model for the main instance,
// directed literal checks, a two-stage cascade and a default-parameter instance.
module tb_param_sync_updown_counter;

    localparam int MAXC = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Main instance WIDTH=4, MAX_COUNT=9
    logic       rst = 1'b1, ce = 1'b0, ud = 1'b1, ld = 1'b0, clr = 1'b0;
    logic [3:0] lv = '0;
    logic [3:0] count;
    logic       terminal, tns, wrap_flag;

    param_sync_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC)) u_dut (
        .clk(clk), .rst(rst), .count_enable(ce), .up_down(ud), .load(ld),
        .load_value(lv), .clear_flag(clr), .count(count), .terminal(terminal),
        .to_next_stage(tns), .wrap_flag(wrap_flag)
    );

    // Cascade: A.to_next_stage feeds B.count_enable
    logic       c_rst = 1'b1, c_ce = 1'b0;
    logic [3:0] a_count, b_count;
    logic       a_term, a_tns, a_flag, b_term, b_tns, b_flag;

    param_sync_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC)) u_a (
        .clk(clk), .rst(c_rst), .count_enable(c_ce), .up_down(1'b1), .load(1'b0),
        .load_value(4'd0), .clear_flag(1'b0), .count(a_count), .terminal(a_term),
        .to_next_stage(a_tns), .wrap_flag(a_flag)
    );

    param_sync_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC)) u_b (
        .clk(clk), .rst(c_rst), .count_enable(a_tns), .up_down(1'b1), .load(1'b0),
        .load_value(4'd0), .clear_flag(1'b0), .count(b_count), .terminal(b_term),
        .to_next_stage(b_tns), .wrap_flag(b_flag)
    );

    // Default parameters (MAX_COUNT=15)
    logic       d_rst = 1'b1, d_ce = 1'b0, d_ud = 1'b1, d_ld = 1'b0;
    logic [3:0] d_lv = '0;
    logic [3:0] d_count;
    logic       d_term, d_tns, d_flag;

    param_sync_updown_counter u_def (
        .clk(clk), .rst(d_rst), .count_enable(d_ce), .up_down(d_ud), .load(d_ld),
        .load_value(d_lv), .clear_flag(1'b0), .count(d_count), .terminal(d_term),
        .to_next_stage(d_tns), .wrap_flag(d_flag)
    );

    // Reference model: plain modular arithmetic on integers
    int m_cnt   = 0;
    bit m_flag  = 0;
    bit m_valid = 0;
    bit m_wrap;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_flag  = 0;
            m_valid = 1;
        end else begin
            m_wrap = 0;
            if (ld) begin
                m_cnt = (int'(lv) > MAXC) ? MAXC : int'(lv);
            end else if (ce) begin
                if (ud) begin
                    m_wrap = (m_cnt == MAXC);
                    m_cnt  = (m_cnt + 1) % (MAXC + 1);
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MAXC) % (MAXC + 1);
                end
            end
            if (m_wrap)   m_flag = 1;
            else if (clr) m_flag = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit exp_term;
            exp_term = ud ? (m_cnt == MAXC) : (m_cnt == 0);
            chk("count", int'(count), m_cnt);
            chk("terminal", int'(terminal), int'(exp_term));
            chk("to_next_stage", int'(tns), int'(exp_term && ce && !ld));
            chk("wrap_flag", int'(wrap_flag), int'(m_flag));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] v,
                        input logic e, input logic u, input logic c);
        rst = r; ld = l; lv = v; ce = e; ud = u; clr = c;
        tick();
    endtask

    initial begin
        #1;
        // Reset 2 clocks, then count up 12 clocks
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("reset_count", int'(count), 0);
        chk("reset_flag", int'(wrap_flag), 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 1, 1, 0);
            if (i == 9) begin
                chk("up_at_9", int'(count), 9);
                chk("up_tns_at_9", int'(tns), 1);
                chk("up_flag_before_wrap", int'(wrap_flag), 0);
            end
            if (i == 10) chk("up_wrap_flag", int'(wrap_flag), 1);
        end
        chk("up_end_count", int'(count), 2);

        // Clear flag, load 3, count down 5
        step(0, 0, 0, 0, 0, 1);
        chk("clear_idle", int'(wrap_flag), 0);
        step(0, 1, 4'd3, 0, 0, 0);
        chk("load3", int'(count), 3);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 1, 0, 0);
            if (i == 3) begin
                chk("down_at_0", int'(count), 0);
                chk("down_term_at_0", int'(terminal), 1);
                chk("down_flag_pre", int'(wrap_flag), 0);
            end
            if (i == 4) begin
                chk("down_wrap_9", int'(count), 9);
                chk("down_wrap_flag", int'(wrap_flag), 1);
            end
        end
        chk("down_end", int'(count), 8);

        // Saturating load with count_enable, no wrap flag
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 4'd14, 1, 1, 0);
        chk("load_sat", int'(count), 9);
        chk("load_no_flag", int'(wrap_flag), 0);
        chk("load_blocks_tns", int'(tns), 0);

        // Set wins over clear on the wrap edge, clear on the next
        step(0, 0, 0, 1, 1, 1);
        chk("set_wins_count", int'(count), 0);
        chk("set_wins_flag", int'(wrap_flag), 1);
        step(0, 0, 0, 1, 1, 1);
        chk("clear_after", int'(wrap_flag), 0);

        // Randomised traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        step(0, 0, 0, 0, 1, 0);

        // Cascade from reset, 25 up clocks
        c_rst = 1'b1; c_ce = 1'b0;
        tick();
        c_rst = 1'b0; c_ce = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("cascade_a", int'(a_count), 5);
        chk("cascade_b", int'(b_count), 2);

        // Defaults: reset at count 7 with load asserted
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0; d_ce = 1'b1; d_ud = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("def_at_7", int'(d_count), 7);
        d_rst = 1'b1; d_ld = 1'b1; d_lv = 4'd12; d_ud = 1'b0;
        tick();
        chk("def_rst_over_load", int'(d_count), 0);
        chk("def_term_in_rst", int'(d_term), 1);
        chk("def_tns_load", int'(d_tns), 0);
        d_rst = 1'b0; d_ld = 1'b0; d_ud = 1'b1;
        tick();
        chk("def_restart", int'(d_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d compares expected completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
